// File: rtl/bp_network_serializer_arbiter.sv
// ============================================================================
// Module   : bp_network_serializer_arbiter
// Brief    : Credit-gated round-robin arbiter feeding a one-entry holding
//            register for a shared network serializer.
//            Optional counters: BP_NETWORK_SERIALIZER_ARBITER_PERF_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_network_serializer_arbiter #(
  parameter int num_req_p           = 2,
  parameter int num_dest_p          = 4,
  parameter int source_data_width_p = 64,
  parameter int credits_p           = 4,
  parameter int dest_id_width_lp    = (num_dest_p > 1) ? $clog2(num_dest_p) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_req_p-1:0]                     valid_i,
  input  logic [num_req_p*source_data_width_p-1:0] data_i,
  output logic [num_req_p-1:0]                     ready_o,
  output logic                                     valid_o,
  output logic [source_data_width_p-1:0]           data_o,
  input  logic                                     ready_i,
  input  logic                                     credit_v_i,
  input  logic [dest_id_width_lp-1:0]              credit_dest_i
`ifdef BP_NETWORK_SERIALIZER_ARBITER_PERF_EN
  ,
  output logic [num_req_p*32-1:0]                  grant_count_o,
  output logic [31:0]                              credit_stall_count_o
`endif
);

  localparam int cred_w_lp = $clog2(credits_p + 1);
  localparam int ptr_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int dw_lp     = source_data_width_p;

  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [dw_lp-1:0]         data_q, data_d;
  logic [ptr_w_lp-1:0]      rr_ptr_q, rr_ptr_d;
  logic [cred_w_lp-1:0]     credit_q [num_dest_p];
  logic [cred_w_lp-1:0]     credit_d [num_dest_p];

  logic [dest_id_width_lp-1:0] dest [num_req_p];
  logic [num_req_p-1:0]        eligible;
  logic [num_req_p-1:0]        grant;
  logic                        any_elig;
  logic [ptr_w_lp-1:0]         win_idx;
  logic [dest_id_width_lp-1:0] win_dest;
  logic [dw_lp-1:0]            win_data;
  logic                        can_load;
  logic                        capture;

  // Out-of-range destinations are never eligible, so they cannot index credits.
  always_comb begin
    for (int k = 0; k < num_req_p; k++) begin
      dest[k]     = data_i[k*dw_lp + dw_lp - dest_id_width_lp +: dest_id_width_lp];
      eligible[k] = valid_i[k] && (int'(dest[k]) < num_dest_p) &&
                    (credit_q[dest[k]] != '0);
    end
  end

  always_comb begin
    grant    = '0;
    any_elig = 1'b0;
    win_idx  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!any_elig && eligible[(int'(rr_ptr_q) + i) % num_req_p]) begin
        any_elig = 1'b1;
        win_idx  = ptr_w_lp'((int'(rr_ptr_q) + i) % num_req_p);
      end
    end
    if (any_elig) grant[win_idx] = 1'b1;
    win_dest = dest[win_idx];
    win_data = data_i[int'(win_idx)*dw_lp +: dw_lp];
  end

  // A full register may refill in the same cycle it drains.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    ready_o  = '0;
    can_load = (state_q == S_EMPTY) || ready_i;
    capture  = can_load && any_elig && !reset_i;
    if (capture) begin
      ready_o  = grant;
      data_d   = win_data;
      state_d  = S_FULL;
      rr_ptr_d = ptr_w_lp'((int'(win_idx) + 1) % num_req_p);
    end else if (state_q == S_FULL && ready_i) begin
      state_d  = S_EMPTY;
    end
  end

  always_comb begin
    for (int d = 0; d < num_dest_p; d++) begin
      credit_d[d] = credit_q[d];
      if (capture && int'(win_dest) == d &&
          !(credit_v_i && int'(credit_dest_i) == d)) begin
        credit_d[d] = credit_q[d] - cred_w_lp'(1);
      end else if (credit_v_i && int'(credit_dest_i) == d &&
                   !(capture && int'(win_dest) == d) &&
                   credit_q[d] != cred_w_lp'(credits_p)) begin
        credit_d[d] = credit_q[d] + cred_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_EMPTY;
      data_q   <= '0;
      rr_ptr_q <= '0;
      for (int d = 0; d < num_dest_p; d++) credit_q[d] <= cred_w_lp'(credits_p);
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
      for (int d = 0; d < num_dest_p; d++) credit_q[d] <= credit_d[d];
    end
  end

  assign valid_o = (state_q == S_FULL);
  assign data_o  = data_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (credit_v_i) begin
        assert (int'(credit_dest_i) < num_dest_p &&
                !(credit_q[credit_dest_i] == cred_w_lp'(credits_p) &&
                  !(capture && win_dest == credit_dest_i)))
          else $warning("credit return overflow on dest %0d", credit_dest_i);
      end
      for (int k = 0; k < num_req_p; k++) begin
        if (valid_i[k]) begin
          assert (int'(dest[k]) < num_dest_p)
            else $warning("source %0d targets invalid dest %0d", k, dest[k]);
        end
      end
    end
  end
`endif

`ifdef BP_NETWORK_SERIALIZER_ARBITER_PERF_EN
  logic [31:0] grant_cnt_q [num_req_p];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_req_p; k++) grant_cnt_q[k] <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (capture) grant_cnt_q[win_idx] <= grant_cnt_q[win_idx] + 32'd1;
      if ((|valid_i) && !any_elig && state_q == S_EMPTY)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < num_req_p; k++) grant_count_o[k*32 +: 32] = grant_cnt_q[k];
  end
  assign credit_stall_count_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_network_serializer_arbiter.sv
// ============================================================================
// Module   : tb_bp_network_serializer_arbiter
// Brief    : Directed self-checking bench for bp_network_serializer_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bp_network_serializer_arbiter;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [1:0]   valid_i;
  logic [127:0] data_i;
  logic [1:0]   ready_o;
  logic         valid_o;
  logic [63:0]  data_o;
  logic         ready_i;
  logic         credit_v_i;
  logic [1:0]   credit_dest_i;
`ifdef BP_NETWORK_SERIALIZER_ARBITER_PERF_EN
  logic [63:0]  grant_count_o;
  logic [31:0]  credit_stall_count_o;
`endif

  int errors = 0;
  int checks = 0;

  bp_network_serializer_arbiter dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .data_o        (data_o),
    .ready_i       (ready_i),
    .credit_v_i    (credit_v_i),
    .credit_dest_i (credit_dest_i)
`ifdef BP_NETWORK_SERIALIZER_ARBITER_PERF_EN
    ,
    .grant_count_o        (grant_count_o),
    .credit_stall_count_o (credit_stall_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] msg(input logic [1:0] dst, input logic [61:0] pl);
    return {dst, pl};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i    = 1'b1;
    valid_i    = '0;
    credit_v_i = 1'b0;
    tick();
    tick();
    reset_i    = 1'b0;
    #1;
  endtask

  initial begin
    reset_i = 1'b1; valid_i = '0; data_i = '0; ready_i = 1'b1;
    credit_v_i = 1'b0; credit_dest_i = '0;
    #1;

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    for (int d = 0; d < 4; d++) chk("rst_credit", 64'(dut.credit_q[d]), 64'd4);
    chk("rst_ptr", 64'(dut.rr_ptr_q), 64'd0);

    // ---------------- single source, credit exhaustion on dest 1 ----------------
    ready_i = 1'b1;
    valid_i = 2'b01;
    for (int m = 0; m < 4; m++) begin
      data_i[63:0] = msg(2'd1, 62'hA0 + 62'(m));
      #1;
      chk("t1_ready", 64'(ready_o), 64'd1);
      tick();
      chk("t1_valid", 64'(valid_o), 64'd1);
      chk("t1_data", data_o, msg(2'd1, 62'hA0 + 62'(m)));
    end
    data_i[63:0] = msg(2'd1, 62'hA4);
    #1;
    chk("t1_stall_ready", 64'(ready_o), 64'd0);
    chk("t1_credit1_zero", 64'(dut.credit_q[1]), 64'd0);
    tick();
    chk("t1_drained", 64'(valid_o), 64'd0);
    chk("t1_stall_ready2", 64'(ready_o), 64'd0);
    credit_v_i = 1'b1; credit_dest_i = 2'd1;
    #1;
    chk("t1_pulse_ready", 64'(ready_o), 64'd0);
    tick();
    credit_v_i = 1'b0;
    #1;
    chk("t1_after_pulse_ready", 64'(ready_o), 64'd1);
    tick();
    valid_i = '0;
    chk("t1_fifth_valid", 64'(valid_o), 64'd1);
    chk("t1_fifth_data", data_o, msg(2'd1, 62'hA4));

    // ---------------- two sources alternate, credits returned each grant ----------------
    do_reset();
    ready_i = 1'b1;
    valid_i = 2'b11;
    data_i  = {msg(2'd2, 62'hC0), msg(2'd0, 62'hB0)};
    credit_v_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      credit_dest_i = (c % 2 == 0) ? 2'd0 : 2'd2;
      #1;
      chk("t2_grant", 64'(ready_o), (c % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      chk("t2_data", data_o, (c % 2 == 0) ? msg(2'd0, 62'hB0) : msg(2'd2, 62'hC0));
    end
    credit_v_i = 1'b0;
    valid_i = '0;
    chk("t2_credit0", 64'(dut.credit_q[0]), 64'd4);
    chk("t2_credit2", 64'(dut.credit_q[2]), 64'd4);

    // ---------------- backpressure ----------------
    do_reset();
    ready_i = 1'b0;
    valid_i = 2'b01;
    data_i[63:0] = msg(2'd1, 62'hD0);
    #1;
    chk("t3_first_ready", 64'(ready_o), 64'd1);
    tick();
    data_i[63:0] = msg(2'd1, 62'hD1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_hold_valid", 64'(valid_o), 64'd1);
      chk("t3_hold_data", data_o, msg(2'd1, 62'hD0));
      chk("t3_hold_ready", 64'(ready_o), 64'd0);
      tick();
    end
    ready_i = 1'b1;
    #1;
    chk("t3_refill_ready", 64'(ready_o), 64'd1);
    tick();
    valid_i = '0;
    chk("t3_refill_valid", 64'(valid_o), 64'd1);
    chk("t3_refill_data", data_o, msg(2'd1, 62'hD1));
    chk("t3_credit1", 64'(dut.credit_q[1]), 64'd2);

    // ---------------- credit starvation ----------------
    do_reset();
    ready_i = 1'b1;
    valid_i = 2'b01;
    data_i  = {msg(2'd3, 62'hF0), msg(2'd2, 62'hE0)};
    repeat (4) tick();
    valid_i = 2'b10;
    repeat (2) tick();
    chk("t4_credit2", 64'(dut.credit_q[2]), 64'd0);
    chk("t4_credit3", 64'(dut.credit_q[3]), 64'd2);
    valid_i = 2'b11;
    #1;
    chk("t4_grant_s1_a", 64'(ready_o), 64'd2);
    tick();
    chk("t4_grant_s1_b", 64'(ready_o), 64'd2);
    tick();
    chk("t4_none", 64'(ready_o), 64'd0);
    credit_v_i = 1'b1; credit_dest_i = 2'd2;
    #1;
    chk("t4_pulse_none", 64'(ready_o), 64'd0);
    tick();
    credit_v_i = 1'b0;
    #1;
    chk("t4_grant_s0", 64'(ready_o), 64'd1);
    valid_i = '0;
    tick();

    // ---------------- credit saturation and same-cycle return ----------------
    do_reset();
    ready_i = 1'b1;
    credit_v_i = 1'b1; credit_dest_i = 2'd3;
    tick();
    credit_v_i = 1'b0;
    chk("t5_saturate", 64'(dut.credit_q[3]), 64'd4);
    valid_i = 2'b01;
    data_i[63:0] = msg(2'd0, 62'h70);
    repeat (3) tick();
    chk("t5_credit0_one", 64'(dut.credit_q[0]), 64'd1);
    credit_v_i = 1'b1; credit_dest_i = 2'd0;
    data_i[63:0] = msg(2'd0, 62'h73);
    #1;
    chk("t5_same_ready", 64'(ready_o), 64'd1);
    tick();
    credit_v_i = 1'b0;
    chk("t5_same_credit", 64'(dut.credit_q[0]), 64'd1);
    chk("t5_full", 64'(valid_o), 64'd1);

    // ---------------- reset while full ----------------
    reset_i = 1'b1;
    #1;
    chk("t6_rst_ready", 64'(ready_o), 64'd0);
    tick();
    reset_i = 1'b0;
    valid_i = '0;
    chk("t6_valid", 64'(valid_o), 64'd0);
    for (int d = 0; d < 4; d++) chk("t6_credit", 64'(dut.credit_q[d]), 64'd4);
    chk("t6_ptr", 64'(dut.rr_ptr_q), 64'd0);
`ifdef BP_NETWORK_SERIALIZER_ARBITER_PERF_EN
    chk("t6_grant_cnt", grant_count_o, 64'd0);
    chk("t6_stall_cnt", 64'(credit_stall_count_o), 64'd0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
